// File: rtl/branch_resolve_pkg.sv
// ---------------------------------------------------------------------------
// rv32imc_types
// Shared types and constants for the execute-stage branch resolution slice.
//   redirect_t  : registered fetch redirect (valid, pc)
//   bp_update_t : registered predictor update (valid, pc, taken, target)
//   br_state_t  : resolution FSM states (IDLE, HOLD)
//   ILEN32_INC / ILEN16_INC : PC increments for 32-bit / 16-bit instructions
// ---------------------------------------------------------------------------
package rv32imc_types;

    localparam logic [31:0] ILEN32_INC = 32'd4;
    localparam logic [31:0] ILEN16_INC = 32'd2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } br_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } redirect_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } bp_update_t;

endpackage

// File: rtl/branch_resolve_target_calc.sv
// ---------------------------------------------------------------------------
// branch_target_calc
// Purely combinational outcome/target/mispredict evaluation for one
// control-flow instruction. No state.
// Ports:
//   is_br, is_jalr      : instruction type (JAL is implied when neither set)
//   compressed          : 16-bit instruction, fall-through is pc+2
//   pc, imm, rs1        : operands for target computation
//   pred_taken/target   : front-end prediction to compare against
//   br_en               : comparator result for conditional branches
//   actual_taken        : resolved direction
//   target              : resolved taken target
//   fall_through        : sequential next PC
//   mispredict          : prediction disagrees with resolution
//   redirect_pc         : PC fetch must restart from on a mispredict
// ---------------------------------------------------------------------------
module branch_target_calc
    import rv32imc_types::*;
(
    input  logic        is_br,
    input  logic        is_jalr,
    input  logic        compressed,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic        br_en,
    output logic        actual_taken,
    output logic [31:0] target,
    output logic [31:0] fall_through,
    output logic        mispredict,
    output logic [31:0] redirect_pc
);

    logic [31:0] target_base;
    logic [31:0] target_sum;

    // JALR adds to rs1 and clears bit 0; branches and JAL are PC-relative.
    // A taken prediction with the wrong target is still a mispredict.
    always_comb begin
        actual_taken = is_br ? br_en : 1'b1;
        target_base  = is_jalr ? rs1 : pc;
        target_sum   = target_base + imm;
        target       = is_jalr ? (target_sum & 32'hFFFF_FFFE) : target_sum;
        fall_through = pc + (compressed ? ILEN16_INC : ILEN32_INC);
        mispredict   = (actual_taken != pred_taken) ||
                       (actual_taken && (target != pred_target));
        redirect_pc  = actual_taken ? target : fall_through;
    end

endmodule

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
// Execute-stage branch resolution. Resolves branch/JAL/JALR, issues a
// registered redirect to fetch over valid/ready on a mispredict, flushes
// younger stages on acceptance, then ignores ex_valid for SQUASH_CYCLES
// cycles while wrong-path instructions drain. Every accepted resolve
// produces a one-cycle registered predictor update.
// Optional build macro: BRANCH_PERF_CNT_EN enables saturating performance
// counters; without it perf_br_cnt/perf_mis_cnt are tied to zero.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   ex_*                           : execute-stage instruction fields
//   br_en                          : comparator result
//   ex_stall                       : hold execute while a redirect waits
//   redirect_valid/pc/ready        : redirect handshake to fetch
//   flush                          : kill younger stages (redirect accepted)
//   bp_upd_valid/pc/taken/target   : predictor update pulse
//   perf_br_cnt, perf_mis_cnt      : resolve and mispredict counters
// ---------------------------------------------------------------------------
module branch_resolve
    import rv32imc_types::*;
#(
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_br,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic             ex_compressed,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic             br_en,
    output logic             ex_stall,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic             flush,
    output logic             bp_upd_valid,
    output logic [31:0]      bp_upd_pc,
    output logic             bp_upd_taken,
    output logic [31:0]      bp_upd_target,
    output logic [CNT_W-1:0] perf_br_cnt,
    output logic [CNT_W-1:0] perf_mis_cnt
);

    localparam logic [3:0] SQUASH_INIT = 4'(SQUASH_CYCLES);

    br_state_t  state_q,    state_d;
    logic [3:0] squash_q,   squash_d;
    redirect_t  redirect_q, redirect_d;
    bp_update_t bp_upd_q,   bp_upd_d;

    logic        actual_taken;
    logic [31:0] target;
    logic [31:0] fall_through;
    logic        mispredict;
    logic [31:0] calc_redirect_pc;
    logic        accept;

    branch_target_calc u_calc (
        .is_br        (ex_is_br),
        .is_jalr      (ex_is_jalr),
        .compressed   (ex_compressed),
        .pc           (ex_pc),
        .imm          (ex_imm),
        .rs1          (ex_rs1),
        .pred_taken   (ex_pred_taken),
        .pred_target  (ex_pred_target),
        .br_en        (br_en),
        .actual_taken (actual_taken),
        .target       (target),
        .fall_through (fall_through),
        .mispredict   (mispredict),
        .redirect_pc  (calc_redirect_pc)
    );

    // Only a control-flow instruction seen while idle and outside the
    // wrong-path drain window is resolved.
    assign accept = ex_valid && (ex_is_br || ex_is_jal || ex_is_jalr) &&
                    (state_q == IDLE) && (squash_q == 4'd0);

    // Next-state logic: resolve in IDLE, wait for fetch to take the redirect
    // in HOLD, and reload the drain counter on the accepting cycle.
    always_comb begin
        state_d        = state_q;
        squash_d       = squash_q;
        redirect_d     = redirect_q;
        bp_upd_d       = bp_upd_q;
        bp_upd_d.valid = 1'b0;
        flush          = 1'b0;
        ex_stall       = 1'b0;

        if (squash_q != 4'd0) begin
            squash_d = squash_q - 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    bp_upd_d.valid  = 1'b1;
                    bp_upd_d.pc     = ex_pc;
                    bp_upd_d.taken  = actual_taken;
                    bp_upd_d.target = target;
                    if (mispredict) begin
                        redirect_d.valid = 1'b1;
                        redirect_d.pc    = calc_redirect_pc;
                        state_d          = HOLD;
                    end
                end
            end
            HOLD: begin
                ex_stall = 1'b1;
                if (redirect_q.valid && redirect_ready) begin
                    flush            = 1'b1;
                    redirect_d.valid = 1'b0;
                    squash_d         = SQUASH_INIT;
                    state_d          = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, redirect and predictor-update registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            squash_q   <= 4'd0;
            redirect_q <= '0;
            bp_upd_q   <= '0;
        end else begin
            state_q    <= state_d;
            squash_q   <= squash_d;
            redirect_q <= redirect_d;
            bp_upd_q   <= bp_upd_d;
        end
    end

    assign redirect_valid = redirect_q.valid;
    assign redirect_pc    = redirect_q.pc;
    assign bp_upd_valid   = bp_upd_q.valid;
    assign bp_upd_pc      = bp_upd_q.pc;
    assign bp_upd_taken   = bp_upd_q.taken;
    assign bp_upd_target  = bp_upd_q.target;

`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q,  br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (accept && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (accept && mispredict && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign perf_br_cnt  = br_cnt_q;
    assign perf_mis_cnt = mis_cnt_q;
`else
    assign perf_br_cnt  = '0;
    assign perf_mis_cnt = '0;
`endif

endmodule
